shift_der_seq: RTL

//  Multi-cycle right shifter for the MIPS execute stage, covering SRL/SRA/SRLV/SRAV.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/shift_der_step.sv | 23 ++
 rtl/shift_der_seq.sv | 99 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions used by the right-shift sequencer.
package mips_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    // R-type funct codes for the right shifts; SRA/SRAV select sign fill.
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;

    function automatic logic funct_is_arith(input logic [5:0] funct);
        return (funct == FUNCT_SRA) || (funct == FUNCT_SRAV);
    endfunction

endpackage

// File: rtl/shift_der_step.sv
// Combinational right shift by k (0..STEP) with a single replicated fill bit.
module shift_der_step
    import mips_pkg::*;
#(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int STEP  = 4,
    parameter int K_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [K_W-1:0]   k,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] fill_mask;

    // Vacated top k bits are forced to the fill value through a mask.
    always_comb begin
        fill_mask = fill ? ~({WIDTH{1'b1}} >> k) : '0;
        result    = (data >> k) | fill_mask;
    end

endmodule

// File: rtl/shift_der_seq.sv
// Multi-cycle SRL/SRA/SRLV/SRAV unit: shifts up to STEP bits per cycle
// and holds busy high so control can stall the pipeline meanwhile.
module shift_der_seq
    import mips_pkg::*;
#(
    parameter int WIDTH   = mips_pkg::WIDTH,
    parameter int STEP    = 4,
    parameter int SHAMT_W = mips_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    localparam int K_W = $clog2(STEP + 1);
    localparam logic [SHAMT_W-1:0] STEP_REM = SHAMT_W'(STEP);
    localparam logic [K_W-1:0]     STEP_K   = K_W'(STEP);

    shift_state_t       state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   shifted;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W-1:0] rem_next;
    logic [K_W-1:0]     k;
    logic               arith_q;
    logic               sign_q;

    // Step size is STEP until the remainder is smaller, so rem never underflows.
    always_comb begin
        k        = (rem > STEP_REM) ? STEP_K : rem[K_W-1:0];
        rem_next = rem - SHAMT_W'(k);
    end

    shift_der_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .K_W   (K_W)
    ) u_step (
        .data   (acc),
        .k      (k),
        .fill   (arith_q & sign_q),
        .result (shifted)
    );

    // Sequencer: capture in IDLE, shift in SHIFT, publish result on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            rem      <= '0;
            arith_q  <= 1'b0;
            sign_q   <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= data_in;
                        rem     <= shamt;
                        arith_q <= arith;
                        sign_q  <= data_in[WIDTH-1];
                        if (shamt == '0) begin
                            data_out <= data_in;
                            state    <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= shifted;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        data_out <= shifted;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);

endmodule
